// File: rtl/reg_cmd_sequencer.sv
// reg_cmd_sequencer
// Accepts one command at a time over a valid/ready handshake. It then drives
// per-cycle strobes into a downstream 4-bit register that can clear, load,
// increment, decrement and shift.
//
// Optional build macro: SEQ_SAT_EN
//   When defined, inc is held off while reg_q==4'hF and dec is held off while
//   reg_q==4'h0, so the downstream register saturates instead of wrapping.
//   A held-off cycle still counts as one of the N repeats.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; cmd_ready high
// EXEC  | issuing one strobe per cycle until the repeat count runs out
// DONE  | one-cycle completion pulse on done, then back to IDLE

module reg_cmd_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [3:0] cmd_data,
  input  logic [1:0] cmd_cnt,
  input  logic       abort,
  input  logic [3:0] reg_q,
  output logic       cl,
  output logic       ld,
  output logic       inc,
  output logic       dec,
  output logic       sr,
  output logic       sl,
  output logic [3:0] ld_data,
  output logic       ir,
  output logic       il,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_ROR  = 3'd6;
  localparam logic [2:0] OP_ROL  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] data_q, data_d;
  logic [1:0] cnt_q, cnt_d;

  logic       accept;
  logic       exec_act;
  logic       inc_ok;
  logic       dec_ok;

  // While reset is held the state is already IDLE, so ready is gated by
  // rst_n to keep the handshake closed until reset is released.
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign ld_data   = data_q;

  // A strobe is issued only in EXEC; an abort in that cycle cancels it.
  assign exec_act  = (state_q == EXEC) && !abort;

`ifdef SEQ_SAT_EN
  assign inc_ok = (reg_q != 4'hF);
  assign dec_ok = (reg_q != 4'h0);
`else
  assign inc_ok = 1'b1;
  assign dec_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latched command fields and remaining-repeat down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_CLR;
      data_q <= 4'h0;
      cnt_q  <= 2'd0;
    end else begin
      op_q   <= op_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in EXEC, pulse in DONE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          // CLR and LOAD run exactly once whatever cmd_cnt says.
          cnt_d   = ((cmd_op == OP_CLR) || (cmd_op == OP_LOAD)) ? 2'd0 : cmd_cnt;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == 2'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobe decode: at most one strobe, chosen by the latched op
  always_comb begin
    cl = 1'b0;
    ld = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    sr = 1'b0;
    sl = 1'b0;
    ir = 1'b0;
    il = 1'b0;
    if (exec_act) begin
      case (op_q)
        OP_CLR:  cl  = 1'b1;
        OP_LOAD: ld  = 1'b1;
        OP_INC:  inc = inc_ok;
        OP_DEC:  dec = dec_ok;
        OP_SHR:  sr  = 1'b1;
        OP_SHL:  sl  = 1'b1;
        OP_ROR: begin
          sr = 1'b1;
          ir = reg_q[0];
        end
        OP_ROL: begin
          sl = 1'b1;
          il = reg_q[3];
        end
        default: begin
          cl = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Testbench for reg_cmd_sequencer: directed scenarios plus randomized
// commands, checked against an arithmetic model of the downstream register.
module tb_reg_cmd_sequencer;

`ifdef SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [1:0] cmd_cnt;
  logic       abort;
  logic [3:0] reg_q;
  logic       cl, ld, inc, dec, sr, sl;
  logic [3:0] ld_data;
  logic       ir, il, busy, done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [3:0] model_val;

  always #5 clk = ~clk;

  reg_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_cnt   (cmd_cnt),
    .abort     (abort),
    .reg_q     (reg_q),
    .cl        (cl),
    .ld        (ld),
    .inc       (inc),
    .dec       (dec),
    .sr        (sr),
    .sl        (sl),
    .ld_data   (ld_data),
    .ir        (ir),
    .il        (il),
    .busy      (busy),
    .done      (done)
  );

  // Downstream 4-bit register driven by the strobes.
  logic [3:0] dreg = 4'h0;
  assign reg_q = dreg;
  always @(posedge clk) begin
    if (cl)       dreg <= 4'h0;
    else if (ld)  dreg <= ld_data;
    else if (inc) dreg <= dreg + 4'h1;
    else if (dec) dreg <= dreg - 4'h1;
    else if (sr)  dreg <= {ir, dreg[3:1]};
    else if (sl)  dreg <= {dreg[2:0], il};
  end

  wire [5:0] strobes = {cl, ld, inc, dec, sr, sl};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Register value after k repeats of op starting from s.
  function automatic logic [3:0] step_val(input logic [2:0] op, input logic [3:0] data,
                                          input logic [3:0] s, input int k);
    int si;
    int v;
    si = int'(s);
    v  = si;
    if (k == 0) return s;
    case (op)
      3'd0: v = 0;
      3'd1: v = int'(data);
      3'd2: v = SAT ? ((si + k > 15) ? 15 : si + k) : (si + k) % 16;
      3'd3: v = SAT ? ((si - k < 0) ? 0 : si - k) : (si - k + 16) % 16;
      3'd4: v = si >> k;
      3'd5: v = (si << k) % 16;
      3'd6: v = ((si >> k) | (si << (4 - k))) % 16;
      default: v = ((si << k) | (si >> (4 - k))) % 16;
    endcase
    return 4'(v);
  endfunction

  // Expected {cl,ld,inc,dec,sr,sl} while the register holds v.
  function automatic logic [5:0] exp_strobe(input logic [2:0] op, input logic [3:0] v,
                                            input logic ab);
    if (ab) return 6'b0;
    case (op)
      3'd0: return 6'b100000;
      3'd1: return 6'b010000;
      3'd2: return (SAT && v == 4'hF) ? 6'b0 : 6'b001000;
      3'd3: return (SAT && v == 4'h0) ? 6'b0 : 6'b000100;
      3'd4, 3'd6: return 6'b000010;
      default: return 6'b000001;
    endcase
  endfunction

  // Issue one command from an idle negedge; abort_at = repeat index to abort in, or -1.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data,
                         input logic [1:0] cnt, input int abort_at);
    int n;
    int done_n;
    logic [3:0] start;
    logic [3:0] v;
    logic exp_ir;
    logic exp_il;
    bit aborted;
    start   = model_val;
    n       = (op < 3'd2) ? 1 : int'(cnt) + 1;
    done_n  = n;
    aborted = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_cnt   = cnt;
    chk("ready_before", 8'(cmd_ready), 8'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_data  = 4'($urandom);
    cmd_cnt   = 2'($urandom);
    for (int k = 0; k < n; k++) begin
      abort = (k == abort_at);
      v = step_val(op, data, start, k);
      exp_ir = (op == 3'd6) && !abort && v[0];
      exp_il = (op == 3'd7) && !abort && v[3];
      @(negedge clk);
      chk("strobes", 8'(strobes), 8'(exp_strobe(op, v, abort)));
      chk("ir_il", 8'({ir, il}), 8'({exp_ir, exp_il}));
      chk("exec_status", 8'({busy, done, cmd_ready}), 8'b100);
      chk("ld_data", 8'(ld_data), 8'(data));
      @(posedge clk); #1;
      if (k == abort_at) begin
        abort   = 1'b0;
        done_n  = k;
        aborted = 1'b1;
        break;
      end
      abort = 1'b0;
    end
    if (aborted) begin
      @(negedge clk);
      chk("abort_idle", 8'({busy, done, cmd_ready}), 8'b001);
      chk("abort_strobes", 8'(strobes), 8'd0);
    end else begin
      abort = 1'($urandom);
      @(negedge clk);
      chk("done_cycle", 8'({busy, done, cmd_ready}), 8'b110);
      chk("done_strobes", 8'(strobes), 8'd0);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("ready_again", 8'({busy, done, cmd_ready}), 8'b001);
      chk("ld_data_hold", 8'(ld_data), 8'(data));
    end
    model_val = step_val(op, data, start, done_n);
    chk("reg_value", 8'(dreg), 8'(model_val));
  endtask

  initial begin
    logic [3:0] start;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_data  = 4'd0;
    cmd_cnt   = 2'd0;
    abort     = 1'b0;
    model_val = 4'h0;
    #3;
    chk("reset_outs", 8'({strobes, ir, il}), 8'd0);
    chk("reset_status", 8'({busy, done, cmd_ready, ld_data}), 8'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 8'(cmd_ready), 8'd1);

    // Directed cases
    run_cmd(3'd1, 4'hA, 2'd3, -1);   // LOAD A, cnt ignored
    run_cmd(3'd1, 4'hE, 2'd0, -1);
    run_cmd(3'd2, 4'h0, 2'd2, -1);   // INC x3 from E
    run_cmd(3'd1, 4'h9, 2'd0, -1);
    run_cmd(3'd7, 4'h0, 2'd0, -1);   // ROL x1 from 1001
    run_cmd(3'd1, 4'hF, 2'd0, -1);
    run_cmd(3'd4, 4'h0, 2'd3, 1);    // SHR x4 aborted in second cycle
    run_cmd(3'd1, 4'h0, 2'd0, -1);
    run_cmd(3'd3, 4'h0, 2'd3, -1);   // DEC from 0
    run_cmd(3'd0, 4'h0, 2'd2, -1);   // CLR

    // Back-to-back with cmd_valid held high: INC x1 repeats every 3 cycles
    start     = model_val;
    cmd_valid = 1'b1;
    cmd_op    = 3'd2;
    cmd_cnt   = 2'd0;
    for (int c = 0; c < 9; c++) begin
      logic [7:0] e;
      logic [3:0] v;
      v = step_val(3'd2, 4'h0, start, c / 3);
      case (c % 3)
        0: e = 8'b1_000000_0;
        1: e = {1'b0, exp_strobe(3'd2, v, 1'b0), 1'b0};
        default: e = 8'b0_000000_1;
      endcase
      chk("b2b_cycle", 8'({cmd_ready, strobes, done}), e);
      if (c == 8) cmd_valid = 1'b0;
      @(negedge clk);
    end
    chk("b2b_ready", 8'(cmd_ready), 8'd1);
    model_val = step_val(3'd2, 4'h0, start, 3);
    chk("b2b_reg", 8'(dreg), 8'(model_val));

    // Reset in the middle of a DEC
    run_cmd(3'd1, 4'h5, 2'd0, -1);
    cmd_valid = 1'b1;
    cmd_op    = 3'd3;
    cmd_cnt   = 2'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_dec", 8'(strobes), 8'b000100);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", 8'({strobes, ir, il}), 8'd0);
    chk("rst_mid_status", 8'({busy, done, cmd_ready, ld_data}), 8'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_outs", 8'({strobes, busy, done}), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 8'({cmd_ready, busy}), 8'b10);
    @(negedge clk);
    chk("rst_no_done", 8'({done, strobes}), 8'd0);
    model_val = 4'h4;
    chk("rst_reg", 8'(dreg), 8'(model_val));

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [1:0] cnt;
      int n;
      int ab;
      op  = 3'($urandom_range(0, 7));
      cnt = 2'($urandom_range(0, 3));
      n   = (op < 3'd2) ? 1 : int'(cnt) + 1;
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_cmd(op, 4'($urandom), cnt, ab);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        abort = 1'($urandom);
        @(negedge clk);
        chk("idle_gap", 8'({cmd_ready, busy, strobes}), 8'b10_000000);
        abort = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_cmd_sequencer.md
REG_CMD_SEQUENCER -- requirements
Module: reg_cmd_sequencer

Interface
REQ-001 SHALL have clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-002 SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have cmd_valid, input, 1 bit: command offered.
REQ-004 SHALL have cmd_ready, output, 1 bit: command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-005 SHALL have cmd_op, input, 3 bits: 0 CLR, 1 LOAD, 2 INC, 3 DEC, 4 SHR, 5 SHL, 6 ROR, 7 ROL.
REQ-006 SHALL have cmd_data, input, 4 bits: LOAD operand.
REQ-007 SHALL have cmd_cnt, input, 2 bits: repeat count N = cmd_cnt+1 (1..4), used by ops 2-7.
REQ-008 SHALL have abort, input, 1 bit: synchronous cancel of the running command.
REQ-009 SHALL have reg_q, input, 4 bits: current value of the downstream 4-bit register.
REQ-010 SHALL have cl, ld, inc, dec, sr, sl, outputs, 1 bit each: strobes to the downstream register.
REQ-011 SHALL have ld_data, output, 4 bits: value for the downstream register's in port.
REQ-012 SHALL have ir and il, outputs, 1 bit each: shift-in bits to the downstream register.
REQ-013 SHALL have busy, output, 1 bit: high while not in IDLE.
REQ-014 SHALL have done, output, 1 bit: one-cycle completion pulse.

Function
REQ-015 SHALL implement the FSM states IDLE, EXEC and DONE.
REQ-016 SHALL drive cmd_ready high only in IDLE.
REQ-017 SHALL, on acceptance, latch op, data and N, and move to EXEC.
REQ-018 SHALL assert in EXEC exactly one strobe per cycle, selected by op: CLR->cl, LOAD->ld, INC->inc, DEC->dec, SHR/ROR->sr, SHL/ROL->sl.
REQ-019 SHALL drive all strobes combinationally from state and latched op, with never more than one strobe high at once.
REQ-020 SHALL stay in EXEC for 1 cycle for CLR and LOAD (cmd_cnt ignored) and for N cycles for ops 2-7, using a 2-bit remaining-count down-counter.
REQ-021 SHALL drive ld_data from the latched cmd_data, and hold it stable from acceptance until the next acceptance.
REQ-022 SHALL drive ir as 0 for SHR and reg_q[0] for ROR, and il as 0 for SHL and reg_q[3] for ROL; ir and il SHALL be 0 in all other cases.
REQ-023 SHALL go from EXEC to DONE after the last strobe cycle, assert done for exactly one cycle in DONE, and then return to IDLE.
REQ-024 SHALL complete a command accepted at edge T with strobes in cycles T+1..T+N, done in cycle T+N+1, and cmd_ready high again in cycle T+N+2.
REQ-025 SHALL ignore cmd_valid while busy, leaving the command pending on the handshake.
REQ-026 SHALL, when abort is high in EXEC, suppress the strobe in that cycle, go to IDLE at the next edge, and not assert done.
REQ-027 SHALL ignore abort in IDLE and in DONE.
REQ-028 SHALL wrap arithmetic modulo 16 in the downstream register, with no carry or borrow output, when SEQ_SAT_EN is undefined.

Reset
REQ-029 SHALL, while rst_n is low, force state IDLE and clear op, ld_data and the remaining count.
REQ-030 SHALL, while rst_n is low, hold all strobes, ir, il, busy and done at 0, and cmd_ready at 0.
REQ-031 SHALL raise cmd_ready in the first cycle after rst_n deasserts.
REQ-032 SHALL, on a reset during EXEC, abandon the command with no further strobes and no done.

Configuration
REQ-033 SHALL provide the macro SEQ_SAT_EN.
REQ-034 SHALL, with SEQ_SAT_EN defined, suppress inc when reg_q==4'hF and suppress dec when reg_q==4'h0, while the cycle still counts toward N and done still pulses.
REQ-035 SHALL, without SEQ_SAT_EN, always issue inc and dec so that the value wraps.

Verification
REQ-036 Bench SHALL cover: LOAD cmd_data=4'hA accepted at T -> ld high in T+1 only, ld_data=4'hA, done in T+2, register=4'hA.
REQ-037 Bench SHALL cover: INC cmd_cnt=2 from 4'hE, no SEQ_SAT_EN -> three inc cycles, register 4'h1, done one cycle after; with SEQ_SAT_EN -> register 4'hF.
REQ-038 Bench SHALL cover: ROL cmd_cnt=0 from 4'b1001 -> sl with il=1 for one cycle, register 4'b0011.
REQ-039 Bench SHALL cover: SHR cmd_cnt=3 from 4'hF with abort in the second EXEC cycle -> exactly one sr, register 4'h7, no done, cmd_ready high the next cycle.
REQ-040 Bench SHALL cover: back-to-back commands with cmd_valid held high -> second command accepted only when cmd_ready returns, no strobe overlap.
REQ-041 Bench SHALL cover: rst_n asserted mid-DEC -> all outputs 0 immediately, cmd_ready 1 the first cycle after release.
